// File: rtl/instruction_encoder_pkg.sv
// Shared opcode constants, format enumeration and immediate limits for the
// RV64 instruction encoder and the decode stage.
package instruction_encoder_pkg;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;

   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_S, FMT_SB, FMT_U, FMT_UJ, FMT_BAD
   } fmt_t;

   typedef enum logic [1:0] {
      BUF_EMPTY, BUF_ONE, BUF_FULL
   } buf_state_t;

   localparam logic signed [63:0] IMM12_MIN = -64'sd2048;
   localparam logic signed [63:0] IMM12_MAX =  64'sd2047;
   localparam logic signed [63:0] IMM_SB_MIN = -64'sd4096;
   localparam logic signed [63:0] IMM_SB_MAX =  64'sd4094;
   localparam logic signed [63:0] IMM_UJ_MIN = -64'sd1048576;
   localparam logic signed [63:0] IMM_UJ_MAX =  64'sd1048574;

   function automatic fmt_t opcode_fmt(input logic [6:0] op);
      fmt_t f;
      case (op)
         OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: f = FMT_I;
         OP_STORE:                           f = FMT_S;
         OP_BRANCH:                          f = FMT_SB;
         OP_LUI, OP_AUIPC:                   f = FMT_U;
         OP_JAL:                             f = FMT_UJ;
         OP_REG, OP_REG32:                   f = FMT_R;
         default:                            f = FMT_BAD;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Field-bundle input and encoded-word output bus of the instruction encoder.
interface instruction_encoder_if #(
   parameter int ADDR_W = 64
);
   logic              in_valid;
   logic              in_ready;
   logic [6:0]        in_opcode;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [2:0]        in_funct3;
   logic [6:0]        in_funct7;
   logic [63:0]       in_imm;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [31:0]       out_word;

   modport slave (
      input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      output in_ready,
      output out_valid, out_addr, out_word,
      input  out_ready
   );

   modport master (
      output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      input  in_ready,
      input  out_valid, out_addr, out_word,
      output out_ready
   );
endinterface

// File: rtl/instruction_encoder_enc_skid_buffer.sv
// Two-entry in-order {addr, word} buffer. The head entry drives the
// registered outputs directly; the second entry absorbs one word of stall.
//
//   state     | meaning
//   BUF_EMPTY | no word held, out_valid low
//   BUF_ONE   | head holds a word
//   BUF_FULL  | head and tail both hold words, no push accepted
module enc_skid_buffer
   import instruction_encoder_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [31:0]       push_word,
   input  logic              out_ready,
   output logic              full,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [31:0]       out_word
);

   buf_state_t        state, state_nxt;
   logic [ADDR_W-1:0] tail_addr;
   logic [31:0]       tail_word;
   logic              pop;

   assign pop       = out_valid && out_ready;
   assign out_valid = (state != BUF_EMPTY);
   assign full      = (state == BUF_FULL);

   // occupancy state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= BUF_EMPTY;
      else        state <= state_nxt;
   end

   // occupancy next-state
   always_comb begin
      state_nxt = state;
      case (state)
         BUF_EMPTY: if (push)         state_nxt = BUF_ONE;
         BUF_ONE:   if (push && !pop) state_nxt = BUF_FULL;
                    else if (!push && pop) state_nxt = BUF_EMPTY;
         BUF_FULL:  if (pop)          state_nxt = BUF_ONE;
         default:                     state_nxt = BUF_EMPTY;
      endcase
   end

   // entry storage; the head is refilled from the tail or the push port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_addr  <= '0;
         out_word  <= '0;
         tail_addr <= '0;
         tail_word <= '0;
      end else begin
         case (state)
            BUF_EMPTY: if (push) begin
               out_addr <= push_addr;
               out_word <= push_word;
            end
            BUF_ONE: if (push && pop) begin
               out_addr <= push_addr;
               out_word <= push_word;
            end else if (push) begin
               tail_addr <= push_addr;
               tail_word <= push_word;
            end
            BUF_FULL: if (pop) begin
               out_addr <= tail_addr;
               out_word <= tail_word;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/instruction_encoder.sv
// RV64 instruction encoder: decodes the format from the opcode, checks the
// immediate and packs the fields into a 32-bit word tagged with its byte
// address. Optional macro ENC_RANGE_CHECK_EN enables immediate range and
// alignment rejection; without it immediates are truncated to field bits.
module instruction_encoder
   import instruction_encoder_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_pc,
   input  logic [ADDR_W-1:0]    pc_init,
   input  logic                 err_clr,
   output logic                 err_flag,
   output logic [ERR_CNT_W-1:0] err_count,
   instruction_encoder_if.slave bus
);

   fmt_t              fmt;
   logic [63:0]       imm;
   logic [31:0]       word;
   logic              imm_ok;
   logic              reject;
   logic              fire;
   logic              push;
   logic              full;
   logic [ADDR_W-1:0] pc;

   assign imm  = bus.in_imm;
   assign fmt  = opcode_fmt(bus.in_opcode);
   assign bus.in_ready = !full && !load_pc;
   assign fire   = bus.in_valid && bus.in_ready;
   assign reject = (fmt == FMT_BAD) || !imm_ok;
   assign push   = fire && !reject;

`ifdef ENC_RANGE_CHECK_EN
   // signed range and alignment check for the immediate of each format
   always_comb begin
      imm_ok = 1'b1;
      case (fmt)
         FMT_I, FMT_S: imm_ok = ($signed(imm) >= IMM12_MIN) && ($signed(imm) <= IMM12_MAX);
         FMT_SB:       imm_ok = ($signed(imm) >= IMM_SB_MIN) && ($signed(imm) <= IMM_SB_MAX)
                                && !imm[0];
         FMT_UJ:       imm_ok = ($signed(imm) >= IMM_UJ_MIN) && ($signed(imm) <= IMM_UJ_MAX)
                                && !imm[0];
         FMT_U:        imm_ok = (imm[11:0] == 12'h000)
                                && ((&imm[63:31]) || !(|imm[63:31]));
         default:      imm_ok = 1'b1;
      endcase
   end
`else
   logic unused_imm_bits;
   assign unused_imm_bits = &{1'b0, imm[63:32]};

   // only unknown opcodes are rejected; immediates are truncated below
   always_comb begin
      imm_ok = 1'b1;
   end
`endif

   // field packing; bits not used by a format are simply not referenced
   always_comb begin
      word = '0;
      case (fmt)
         FMT_R:  word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         bus.in_rd, bus.in_opcode};
         FMT_I:  word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
         FMT_S:  word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         imm[4:0], bus.in_opcode};
         FMT_SB: word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         imm[4:1], imm[11], bus.in_opcode};
         FMT_U:  word = {imm[31:12], bus.in_rd, bus.in_opcode};
         FMT_UJ: word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
         default: word = '0;
      endcase
   end

   // address counter; advances only for words that enter the buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       pc <= '0;
      else if (load_pc) pc <= pc_init;
      else if (push)    pc <= pc + ADDR_W'(4);
   end

   // sticky error flag and saturating count; a new error beats err_clr
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_flag  <= 1'b0;
         err_count <= '0;
      end else if (fire && reject) begin
         err_flag <= 1'b1;
         if (err_clr)                err_count <= ERR_CNT_W'(1);
         else if (err_count != '1)   err_count <= err_count + ERR_CNT_W'(1);
      end else if (err_clr) begin
         err_flag  <= 1'b0;
         err_count <= '0;
      end
   end

   enc_skid_buffer #(.ADDR_W(ADDR_W)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_addr (pc),
      .push_word (word),
      .out_ready (bus.out_ready),
      .full      (full),
      .out_valid (bus.out_valid),
      .out_addr  (bus.out_addr),
      .out_word  (bus.out_word)
   );

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: stimulus pushes expected
// {addr, word} pairs, a negedge monitor pops and compares emitted words.
module tb_instruction_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_pc;
   logic [63:0] pc_init;
   logic        err_clr;
   logic        err_flag;
   logic [7:0]  err_count;

   always #5 clk = ~clk;

   instruction_encoder_if #(.ADDR_W(64)) bus ();

   instruction_encoder #(.ADDR_W(64), .ERR_CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_pc   (load_pc),
      .pc_init   (pc_init),
      .err_clr   (err_clr),
      .err_flag  (err_flag),
      .err_count (err_count),
      .bus       (bus)
   );

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] word;
   } exp_t;

   exp_t        sb_q[$];
   logic [63:0] model_pc;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // monitor: compares the presented word against the scoreboard head,
   // including while stalled, and retires it on handshake
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_word: got addr 0x%0h word 0x%0h, expected none",
                        bus.out_addr, bus.out_word);
            end else begin
               check("out_addr", bus.out_addr, sb_q[0].addr);
               check("out_word", {32'h0, bus.out_word}, {32'h0, sb_q[0].word});
               if (bus.out_ready) void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] imm);
      bus.in_valid  = 1'b1;
      bus.in_opcode = op;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_funct3 = f3;
      bus.in_funct7 = f7;
      bus.in_imm    = imm;
   endtask

   task automatic complete(input bit reject, input logic [31:0] word);
      int n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: in_ready 0, expected 1 within 50 cycles");
      end else if (!reject) begin
         sb_q.push_back({model_pc, word});
         model_pc = model_pc + 64'd4;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
   endtask

   task automatic do_load_pc(input logic [63:0] v);
      load_pc = 1'b1;
      pc_init = v;
      @(negedge clk);
      check("in_ready_load_pc", {63'h0, bus.in_ready}, 64'h0);
      @(posedge clk);
      #1 load_pc = 1'b0;
      model_pc = v;
   endtask

   initial begin
      rst_n = 1'b0;
      load_pc = 1'b0;
      pc_init = '0;
      err_clr = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_opcode = '0;
      bus.in_rd = '0;
      bus.in_rs1 = '0;
      bus.in_rs2 = '0;
      bus.in_funct3 = '0;
      bus.in_funct7 = '0;
      bus.in_imm = '0;
      bus.out_ready = 1'b1;
      model_pc = '0;

      #12;
      check("rst_in_ready",  {63'h0, bus.in_ready}, 64'h1);
      check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
      check("rst_out_addr",  bus.out_addr, 64'h0);
      check("rst_out_word",  {32'h0, bus.out_word}, 64'h0);
      check("rst_err_flag",  {63'h0, err_flag}, 64'h0);
      check("rst_err_count", {56'h0, err_count}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // addi x1,x2,5 ; sw x5,8(x2) ; addi x3,x0,-1 ; sub x5,x6,x7 ; lui x10,0x12345
      drive(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd5);
      complete(1'b0, 32'h00510093);
      drive(7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 64'd8);
      complete(1'b0, 32'h00512423);
      drive(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      complete(1'b0, 32'hFFF00193);
      drive(7'b0110011, 5'd5, 5'd6, 5'd7, 3'd0, 7'b0100000, 64'hDEAD);
      complete(1'b0, 32'h407302B3);
      drive(7'b0110111, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 64'h12345000);
      complete(1'b0, 32'h12345537);
      idle(4);

      // unknown opcode rejects, counting, and error winning over err_clr
      drive(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 64'd0);
      complete(1'b1, 32'h0);
      check("err_flag_bad_op",  {63'h0, err_flag}, 64'h1);
      check("err_count_bad_op", {56'h0, err_count}, 64'h1);
      drive(7'h00, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 64'd0);
      complete(1'b1, 32'h0);
      check("err_count_two", {56'h0, err_count}, 64'h2);
      err_clr = 1'b1;
      drive(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
      complete(1'b1, 32'h0);
      err_clr = 1'b0;
      check("err_clr_vs_err_flag",  {63'h0, err_flag}, 64'h1);
      check("err_clr_vs_err_count", {56'h0, err_count}, 64'h1);
      pulse_clr();
      check("err_clr_flag",  {63'h0, err_flag}, 64'h0);
      check("err_clr_count", {56'h0, err_count}, 64'h0);

      // beq x1,x2,3 : misaligned branch offset
      drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd3);
`ifdef ENC_RANGE_CHECK_EN
      complete(1'b1, 32'h0);
      check("beq_odd_err_flag",  {63'h0, err_flag}, 64'h1);
      check("beq_odd_err_count", {56'h0, err_count}, 64'h1);
`else
      complete(1'b0, 32'h00208163);
      check("beq_odd_err_flag",  {63'h0, err_flag}, 64'h0);
      check("beq_odd_err_count", {56'h0, err_count}, 64'h0);
`endif
      pulse_clr();
      check("beq_clr_flag",  {63'h0, err_flag}, 64'h0);
      check("beq_clr_count", {56'h0, err_count}, 64'h0);

      // boundary immediates
      drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd4094);
      complete(1'b0, 32'h7E208FE3);
      drive(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
`ifdef ENC_RANGE_CHECK_EN
      complete(1'b1, 32'h0);
      check("addi_2048_err", {63'h0, err_flag}, 64'h1);
      drive(7'b0010111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1001);
      complete(1'b1, 32'h0);
      check("auipc_low_bits_err_count", {56'h0, err_count}, 64'h2);
      pulse_clr();
`else
      complete(1'b0, 32'h80000013);
      drive(7'b0010111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1001);
      complete(1'b0, 32'h00001017);
`endif
      idle(4);

      // backpressure: two words buffered, third held off
      do_load_pc(64'h0);
      bus.out_ready = 1'b0;
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1);
      complete(1'b0, 32'h00100093);
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2);
      complete(1'b0, 32'h00200093);
      drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3);
      repeat (3) begin
         @(negedge clk);
         check("in_ready_full", {63'h0, bus.in_ready}, 64'h0);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      complete(1'b0, 32'h00300093);

      // load_pc while words are in flight, then jal x0,-4 twice
      do_load_pc(64'h1000);
      drive(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFC);
      complete(1'b0, 32'hFFDFF06F);
      drive(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFC);
      complete(1'b0, 32'hFFDFF06F);
      drive(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFF0_0000);
      complete(1'b0, 32'h8000006F);
      idle(4);

      // asynchronous reset with buffer full and err_flag set
      drive(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
      complete(1'b1, 32'h0);
      bus.out_ready = 1'b0;
      drive(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd5);
      complete(1'b0, 32'h00510093);
      drive(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd5);
      complete(1'b0, 32'h00510093);
      check("pre_rst_in_ready", {63'h0, bus.in_ready}, 64'h0);
      check("pre_rst_err_flag", {63'h0, err_flag}, 64'h1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
      check("mid_rst_in_ready",  {63'h0, bus.in_ready}, 64'h1);
      check("mid_rst_err_count", {56'h0, err_count}, 64'h0);
      check("mid_rst_err_flag",  {63'h0, err_flag}, 64'h0);
      sb_q.delete();
      model_pc = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd5);
      complete(1'b0, 32'h00510093);

      begin
         int n = 0;
         while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
         end
      end
      #1;
      check("drain_queue_empty", 64'(sb_q.size()), 64'h0);
      @(negedge clk);
      check("drain_out_valid", {63'h0, bus.out_valid}, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Streaming RV64 instruction encoder: accepts decoded fields (opcode, registers, funct fields, 64-bit signed immediate), range-checks the immediate for the opcode's format, and packs the fields into a 32-bit instruction word. This is the inverse of the immediate generator in the decode stage. It feeds program images into instruction memory (boot loader, self-test program builder) and emits each word with its target byte address. A 2-entry output buffer decouples producer and memory writer.

## Interface
- ADDR_W, 64, width of address counter and out_addr
- ERR_CNT_W, 8, width of saturating error counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_pc  in  1  load address counter from pc_init
- pc_init  in  ADDR_W  byte address of next emitted word
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_opcode  in  7  instruction opcode
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3; in_funct7  in  7  function fields
- in_imm  in  64  signed immediate (byte offset for SB/UJ; full value, low 12 bits zero, for U)
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer accepts word
- out_addr  out  ADDR_W  byte address of out_word
- out_word  out  32  encoded instruction
- err_flag  out  1  sticky: an input bundle was rejected
- err_count  out  ERR_CNT_W  rejected bundles, saturating
- err_clr  in  1  clears err_flag and err_count

## Operation
- Format by opcode:
  - I: 0010011, 0000011, 1100111, 0011011
  - S: 0100011
  - SB: 1100011
  - U: 0110111, 0010111
  - UJ: 1101111
  - R: 0110011, 0111011 (in_imm ignored)
  - any other opcode: error
- Packing: standard RV field placement. Unused fields for a format are ignored.
  - I: imm[11:0] → [31:20]
  - S: imm[11:5] → [31:25], imm[4:0] → [11:7]
  - SB: imm[12|10:5] → [31:25], imm[4:1|11] → [11:7]
  - U: imm[31:12] → [31:12]
  - UJ: imm[20|10:1|11|19:12] → [31:12]
- Range checks, all signed:
  - I/S: −2048..2047
  - SB: −4096..4094, bit 0 = 0
  - UJ: −2^20..2^20−2, bit 0 = 0
  - U: imm[11:0] = 0 and imm[63:31] all equal
- Accepted valid bundle: packed word and current pc are written to the buffer; pc += 4 (wraps modulo 2^ADDR_W).
- Rejected bundle: consumed (handshake completes) but produces no output and pc is unchanged. err_flag ← 1; err_count +1, saturating at all-ones.
- err_clr together with a new error in the same cycle: the error wins (err_flag = 1, err_count = 1).
- load_pc: pc ← pc_init; in_ready forced 0 that cycle; buffered words keep their original addresses.
- Buffer FSM on occupancy: EMPTY → ONE on push; ONE → FULL on push without pop; FULL → ONE on pop; ONE → EMPTY on pop without push; push+pop in ONE stays ONE.
- Words leave the buffer strictly in order.

## Timing
- Reset values:
  - in_ready = 1, out_valid = 0
  - out_addr = 0, out_word = 0
  - err_flag = 0, err_count = 0
  - pc = 0, buffer EMPTY
- Reset mid-operation discards all buffered words immediately (asynchronous).
- Latency: out_valid rises the cycle after acceptance when the buffer was empty. Throughput is 1 word/cycle with out_ready held high.
- in_ready = !FULL && !load_pc. It is derived from registered state, with no same-cycle combinational path from out_ready. A pop in FULL frees a slot from the next cycle.
- out_valid/out_addr/out_word are registered. They are held stable while out_valid && !out_ready.
- A rejected bundle never changes buffer state.

## Configuration
- ENC_RANGE_CHECK_EN defined: range and alignment checks above are active, and rejects are counted.
- ENC_RANGE_CHECK_EN undefined:
  - Immediates are silently truncated to their field bits, and bit 0 is dropped for SB/UJ.
  - Only unknown opcodes are rejected.
  - err logic remains present.

## Structure
- Shared package/header holds:
  - opcode constants
  - format enumeration (FMT_R, FMT_I, FMT_S, FMT_SB, FMT_U, FMT_UJ, FMT_BAD)
  - immediate range limits
- The decode stage uses the same opcode constants.
- Sub-module enc_skid_buffer holds the 2-entry {addr, word} buffer and the occupancy FSM.
- Format decode, range check and packing are combinational in the top level.

## Test plan
- addi: opcode 0010011, rd=1, rs1=2, funct3=0, imm=5, pc=0 → next cycle out_word=0x00510093, out_addr=0.
- sw: opcode 0100011, rs1=2, rs2=5, funct3=010, imm=8 → out_word=0x00512423; next bundle gets out_addr 4.
- beq with imm=3: with macro → no output, err_flag=1, err_count=1, pc unchanged. Without macro → word emitted with imm bit 0 dropped. Then err_clr → both 0.
- Backpressure: out_ready=0, present three valid addi bundles → two accepted, in_ready=0 while third held. Raise out_ready → addresses 0, 4, 8 in order, with no loss or duplication.
- load_pc with pc_init=0x1000, then jal rd=0, imm=−4 → out_addr=0x1000, out_word=0xFFDFF06F. Second jal gets out_addr=0x1004.
- Buffer FULL with err_flag set, pulse rst_n low → out_valid=0, in_ready=1, err_count=0, next word at out_addr 0.
